// File: rtl/hd_sdi_crc_insert.sv
// HD-SDI receive stage: detects TRS on Y, tracks the EAV/LN/CR word positions and
// computes, checks and inserts the per-channel CRC-18, with one clock of latency.
module hd_sdi_crc_insert #(
  parameter bit          INSERT_EN = 1'b1,
  parameter logic [19:0] IDLE_VID  = {10'h040, 10'h200}
) (
  input  logic        i_clk,
  input  logic        rst_n,
  input  logic [19:0] i_vid,
  output logic [19:0] o_vid,
  output logic        o_eav,
  output logic        o_sav,
  output logic [10:0] o_ln,
  output logic        o_crc_err_y,
  output logic        o_crc_err_c
);

  localparam logic [2:0] S_HBLANK = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_LN0    = 3'd2;
  localparam logic [2:0] S_LN1    = 3'd3;
  localparam logic [2:0] S_CR0    = 3'd4;
  localparam logic [2:0] S_CR1    = 3'd5;

  // x^18+x^5+x^4+1 bit-reversed, because words enter LSB first and the register shifts right
  localparam logic [17:0] CRC_POLY_REV = 18'h23000;

  function automatic logic [17:0] crc_step10(input logic [17:0] crc, input logic [9:0] d);
    logic [17:0] r;
    logic        fb;
    r = crc;
    for (int i = 0; i < 10; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[17:1]} ^ (fb ? CRC_POLY_REV : 18'h0);
    end
    return r;
  endfunction

  logic [2:0]  state, state_next;
  logic [9:0]  y, c, y_d1, y_d2, y_d3;
  logic [17:0] crc_y, crc_c;
  logic        crc_valid, abort_r, err_y_pend, err_c_pend;
  logic [6:0]  ln_lo;
  logic [3:0]  ln_hi;
  logic        trs_xyz, eav_det, sav_det, in_trs, in_cr, abort_now, chk_en, accum;
  logic [9:0]  cr_y_word, cr_c_word;

  assign y = i_vid[19:10];
  assign c = i_vid[9:0];

  assign trs_xyz = (y_d3 == 10'h3FF) && (y_d2 == 10'h000) && (y_d1 == 10'h000) && y[9];
  assign eav_det = trs_xyz &&  y[6];
  assign sav_det = trs_xyz && !y[6];

  // A TRS preamble landing in a CR slot means the line was cut short: leave it intact
  // so downstream still sees the TRS, and skip the check for that line.
  assign in_trs = (y == 10'h3FF)
               || ((y_d1 == 10'h3FF) && (y == 10'h000))
               || ((y_d2 == 10'h3FF) && (y_d1 == 10'h000) && (y == 10'h000))
               || trs_xyz;

  assign in_cr     = (state == S_CR0) || (state == S_CR1);
  assign abort_now = in_trs || ((state == S_CR1) && abort_r);
  assign chk_en    = in_cr && crc_valid && !abort_now;
  assign accum     = ((state == S_ACTIVE) || (state == S_LN0) || (state == S_LN1)) && !sav_det;

  assign cr_y_word = (state == S_CR1) ? {~crc_y[17], crc_y[17:9]} : {~crc_y[8], crc_y[8:0]};
  assign cr_c_word = (state == S_CR1) ? {~crc_c[17], crc_c[17:9]} : {~crc_c[8], crc_c[8:0]};

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      S_LN0:   state_next = S_LN1;
      S_LN1:   state_next = S_CR0;
      S_CR0:   state_next = S_CR1;
      S_CR1:   state_next = S_HBLANK;
      S_HBLANK,
      S_ACTIVE: state_next = state;
      default: state_next = S_HBLANK;
    endcase
    if (sav_det)      state_next = S_ACTIVE;
    else if (eav_det) state_next = S_LN0;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HBLANK;
      y_d1        <= '0;
      y_d2        <= '0;
      y_d3        <= '0;
      crc_y       <= '0;
      crc_c       <= '0;
      crc_valid   <= 1'b0;
      abort_r     <= 1'b0;
      err_y_pend  <= 1'b0;
      err_c_pend  <= 1'b0;
      ln_lo       <= '0;
      ln_hi       <= '0;
      o_vid       <= IDLE_VID;
      o_eav       <= 1'b0;
      o_sav       <= 1'b0;
      o_ln        <= '0;
      o_crc_err_y <= 1'b0;
      o_crc_err_c <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register sees pre-edge values of the others.
      state <= state_next;
      y_d1  <= y;
      y_d2  <= y_d1;
      y_d3  <= y_d2;

      if (sav_det) begin
        crc_y     <= '0;
        crc_c     <= '0;
        crc_valid <= 1'b1;
      end else if (accum) begin
        crc_y <= crc_step10(crc_y, y);
        crc_c <= crc_step10(crc_c, c);
      end

      if (state == S_LN0) ln_lo <= y[8:2];
      if (state == S_LN1) ln_hi <= y[5:2];
      if (state == S_CR0) begin
        o_ln       <= {ln_hi, ln_lo};
        err_y_pend <= (y != cr_y_word);
        err_c_pend <= (c != cr_c_word);
      end
      abort_r <= (state == S_CR0) && in_trs;

      o_crc_err_y <= (state == S_CR1) && chk_en && (err_y_pend || (y != cr_y_word));
      o_crc_err_c <= (state == S_CR1) && chk_en && (err_c_pend || (c != cr_c_word));

      o_vid <= (INSERT_EN && chk_en) ? {cr_y_word, cr_c_word} : i_vid;
      o_eav <= eav_det;
      o_sav <= sav_det;
    end
  end

endmodule

// File: tb/tb_hd_sdi_crc_insert.sv
// Bench for hd_sdi_crc_insert: builds lines word by word, predicts CR words with a
// polynomial-division CRC model and checks every output word of two DUT variants.
module tb_hd_sdi_crc_insert;

  localparam logic [19:0] IDLE = {10'h040, 10'h200};

  logic        i_clk, rst_n;
  logic [19:0] i_vid;
  logic [19:0] vid_m, vid_k;
  logic        eav_m, sav_m, ey_m, ec_m, eav_k, sav_k, ey_k, ec_k;
  logic [10:0] ln_m, ln_k;

  hd_sdi_crc_insert #(.INSERT_EN(1'b1), .IDLE_VID(IDLE)) dut (
    .i_clk(i_clk), .rst_n(rst_n), .i_vid(i_vid), .o_vid(vid_m), .o_eav(eav_m), .o_sav(sav_m),
    .o_ln(ln_m), .o_crc_err_y(ey_m), .o_crc_err_c(ec_m));

  hd_sdi_crc_insert #(.INSERT_EN(1'b0), .IDLE_VID(IDLE)) dut_chk (
    .i_clk(i_clk), .rst_n(rst_n), .i_vid(i_vid), .o_vid(vid_k), .o_eav(eav_k), .o_sav(sav_k),
    .o_ln(ln_k), .o_crc_err_y(ey_k), .o_crc_err_c(ec_k));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          tests, fails;
  string       phase;
  logic [23:0] exp_m, exp_k;
  bit          pend;
  logic [9:0]  y_q[$], c_q[$];
  bit          sav_seen;
  logic [10:0] prev_ln;
  logic [19:0] last_cr0, last_cr1;
  logic [39:0] first_cr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s/%s: got %0h want %0h", phase, tag, got, want);
    end
  endtask

  // Remainder of M(x)*x^18 mod G(x), bits taken LSB first per word, then bit-reversed
  // into the register order used for the CR words.
  function automatic logic [17:0] golden_crc(input logic [9:0] w[$]);
    logic [17:0] rem, crc;
    logic        top;
    rem = '0;
    foreach (w[k]) begin
      for (int b = 0; b < 10; b++) begin
        top = rem[17] ^ w[k][b];
        rem = {rem[16:0], 1'b0};
        if (top) rem = rem ^ 18'h00031;
      end
    end
    for (int j = 0; j < 18; j++) crc[j] = rem[17-j];
    return crc;
  endfunction

  // Drive one word; the previous word's outputs are checked first (exactly 1 clock later).
  task automatic put(input logic [19:0] in, input logic [19:0] out_m,
                     input logic eav, input logic sav, input logic ey, input logic ec);
    @(negedge i_clk);
    if (pend) begin
      check("out", {40'b0, vid_m, eav_m, sav_m, ey_m, ec_m}, {40'b0, exp_m});
      check("out_chk", {40'b0, vid_k, eav_k, sav_k, ey_k, ec_k}, {40'b0, exp_k});
    end
    i_vid = in;
    exp_m = {out_m, eav, sav, ey, ec};
    exp_k = {in, eav, sav, ey, ec};
    pend  = 1'b1;
  endtask

  task automatic put_pass(input logic [9:0] y, input logic [9:0] c);
    put({y, c}, {y, c}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    @(negedge i_clk);
    if (pend) begin
      check("out", {40'b0, vid_m, eav_m, sav_m, ey_m, ec_m}, {40'b0, exp_m});
      check("out_chk", {40'b0, vid_k, eav_k, sav_k, ey_k, ec_k}, {40'b0, exp_k});
    end
    pend = 1'b0;
  endtask

  task automatic send_trs(input logic [9:0] xyz);
    put_pass(10'h3FF, 10'h3FF);
    put_pass(10'h000, 10'h000);
    put_pass(10'h000, 10'h000);
    put({xyz, xyz}, {xyz, xyz}, xyz[6], ~xyz[6], 1'b0, 1'b0);
    if (xyz[6]) begin
      y_q.push_back(10'h3FF); y_q.push_back(10'h000); y_q.push_back(10'h000); y_q.push_back(xyz);
      c_q.push_back(10'h3FF); c_q.push_back(10'h000); c_q.push_back(10'h000); c_q.push_back(xyz);
    end else begin
      y_q.delete();
      c_q.delete();
      sav_seen = 1'b1;
    end
  endtask

  task automatic send_active(input int n, input bit zero);
    logic [9:0] y, c;
    for (int i = 0; i < n; i++) begin
      y = zero ? 10'h000 : 10'($urandom_range(1019, 4));
      c = zero ? 10'h000 : 10'($urandom_range(1019, 4));
      put_pass(y, c);
      y_q.push_back(y);
      c_q.push_back(c);
    end
  endtask

  task automatic send_eav_ln(input logic [10:0] l);
    logic [9:0] w0, w1;
    send_trs(10'h274);
    w0 = {~l[6], l[6:0], 2'b00};
    w1 = {2'b10, 2'b00, l[10:7], 2'b00};
    put_pass(w0, w0);
    put_pass(w1, w1);
    y_q.push_back(w0); y_q.push_back(w1);
    c_q.push_back(w0); c_q.push_back(w1);
  endtask

  // mode 0: incoming CR words 000; 1: Y CR0 off by one bit, rest correct; 2: random
  task automatic send_cr(input int mode, input logic [10:0] l);
    logic [17:0] cy, cc;
    logic [9:0]  gy0, gy1, gc0, gc1, iy0, iy1, ic0, ic1;
    logic        ey, ec;
    cy  = golden_crc(y_q);
    cc  = golden_crc(c_q);
    gy0 = {~cy[8], cy[8:0]};  gy1 = {~cy[17], cy[17:9]};
    gc0 = {~cc[8], cc[8:0]};  gc1 = {~cc[17], cc[17:9]};
    case (mode)
      0: begin iy0 = '0; iy1 = '0; ic0 = '0; ic1 = '0; end
      1: begin iy0 = gy0 ^ 10'h001; iy1 = gy1; ic0 = gc0; ic1 = gc1; end
      default: begin
        iy0 = 10'($urandom_range(1019, 4)); iy1 = 10'($urandom_range(1019, 4));
        ic0 = 10'($urandom_range(1019, 4)); ic1 = 10'($urandom_range(1019, 4));
      end
    endcase
    ey = sav_seen && ((iy0 != gy0) || (iy1 != gy1));
    ec = sav_seen && ((ic0 != gc0) || (ic1 != gc1));
    put({iy0, ic0}, sav_seen ? {gy0, gc0} : {iy0, ic0}, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ln_hold", {53'b0, ln_m}, {53'b0, prev_ln});
    put({iy1, ic1}, sav_seen ? {gy1, gc1} : {iy1, ic1}, 1'b0, 1'b0, ey, ec);
    check("ln_upd", {53'b0, ln_m}, {53'b0, l});
    check("ln_upd_chk", {53'b0, ln_k}, {53'b0, l});
    prev_ln  = l;
    last_cr0 = vid_m;
    put_pass(10'h040, 10'h200);
    last_cr1 = vid_m;
    for (int i = 0; i < 15; i++) put_pass(10'h040, 10'h200);
  endtask

  task automatic send_line(input int n, input bit zero, input logic [10:0] l,
                           input int mode, input bit is_short);
    send_trs(10'h200);
    send_active(n, zero);
    send_eav_ln(l);
    if (is_short) prev_ln = l;
    else          send_cr(mode, l);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    pend     = 1'b0;
    sav_seen = 1'b0;
    prev_ln  = '0;
    phase    = "reset";
    rst_n    = 1'b0;
    i_vid    = IDLE;
    repeat (3) @(negedge i_clk);
    check("rst_vid", {44'b0, vid_m}, {44'b0, IDLE});
    check("rst_vid_chk", {44'b0, vid_k}, {44'b0, IDLE});
    check("rst_strb", {60'b0, eav_m, sav_m, ey_m, ec_m}, 64'b0);
    check("rst_ln", {53'b0, ln_m}, 64'b0);
    rst_n = 1'b1;

    phase = "nominal";
    for (int i = 0; i < 8; i++) put_pass(10'h040, 10'h200);
    send_line(1920, 1'b0, 11'd42, 0, 1'b0);

    phase = "reset_mid";
    send_trs(10'h200);
    send_active(100, 1'b0);
    flush();
    rst_n = 1'b0;
    #1;
    check("mid_vid", {44'b0, vid_m}, {44'b0, IDLE});
    check("mid_strb", {60'b0, eav_m, sav_m, ey_m, ec_m}, 64'b0);
    check("mid_ln", {53'b0, ln_m}, 64'b0);
    i_vid    = IDLE;
    sav_seen = 1'b0;
    prev_ln  = '0;
    repeat (2) @(negedge i_clk);
    check("mid_vid_hold", {44'b0, vid_m}, {44'b0, IDLE});
    rst_n = 1'b1;

    phase = "no_sav";
    for (int i = 0; i < 4; i++) put_pass(10'h040, 10'h200);
    send_eav_ln(11'd7);
    send_cr(2, 11'd7);

    phase = "zero";
    for (int k = 0; k < 4; k++) begin
      send_line(1920, 1'b1, 11'd5, 0, 1'b0);
      if (k == 0) first_cr = {last_cr0, last_cr1};
      else        check("zero_repeat", {24'b0, last_cr0, last_cr1}, {24'b0, first_cr});
    end

    phase = "check";
    send_line(200, 1'b0, 11'd43, 1, 1'b0);

    phase = "short";
    send_line(64, 1'b0, 11'd44, 0, 1'b1);
    send_line(64, 1'b0, 11'd45, 0, 1'b0);

    phase = "wrap";
    send_line(64, 1'b0, 11'd1125, 0, 1'b0);
    send_line(64, 1'b0, 11'd1, 0, 1'b0);

    flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
